// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, EX branch flushes, multi-cycle multiply freezes.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int ZERO_REG   = 31,
    parameter int MUL_CYCLES = 4
`ifdef PIPE_STALL_CNT_EN
    , parameter int CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_is_mul,
    input  logic             ex_br_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mul_busy
`ifdef PIPE_STALL_CNT_EN
    , output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam int MC_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [MC_W-1:0] mul_cnt_q, mul_cnt_d;
    logic            load_use;

    assign load_use = ex_mem_read && (ex_rd != REG_W'(ZERO_REG)) &&
                      ((id_uses_rn && (id_rn == ex_rd)) ||
                       (id_uses_rm && (id_rm == ex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mul_cnt_d    = mul_cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mul_busy     = 1'b0;
        if (reset) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (ex_br_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (ex_is_mul && (MUL_CYCLES > 1)) begin
                // Freeze front end; EX/MEM receives a bubble while MEM/WB keeps draining.
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                mul_cnt_d    = MC_W'(MUL_CYCLES - 1);
                state_d      = ST_MUL;
            end else if (load_use) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end else begin
            mul_busy = 1'b1;
            if (mul_cnt_q > MC_W'(1)) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_en     = 1'b0;
                ex_mem_flush = 1'b1;
                mul_cnt_d    = mul_cnt_q - MC_W'(1);
            end else begin
                mul_cnt_d = '0;
                state_d   = ST_RUN;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB).
- Drives the enable and flush inputs of every pipeline register built from enabled flip-flops.
- Resolves three events: load-use hazards, taken branches resolved in EX, and multi-cycle multiplies that occupy EX.
- Freezes or bubbles stages so that no instruction is lost or duplicated.

Parameters:
- REG_W, 5, register-index width.
- ZERO_REG, 31, index of XZR; never a hazard source.
- MUL_CYCLES, 4, total cycles a multiply occupies EX; must be >= 1; 1 means no stall.
- CNT_W, 32, stall counter width (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rn  in  REG_W  first source register of the instruction in ID.
- id_rm  in  REG_W  second source register of the instruction in ID.
- id_uses_rn  in  1  ID instruction reads id_rn.
- id_uses_rm  in  1  ID instruction reads id_rm.
- ex_rd  in  REG_W  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_is_mul  in  1  EX instruction is a multiply.
- ex_br_taken  in  1  EX instruction is a taken branch.
- pc_en  out  1  PC write enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load NOP into ID/EX.
- ex_mem_flush  out  1  load NOP into EX/MEM.
- mul_busy  out  1  state is MUL.

Behaviour:
- Outputs are combinational from state and inputs (Mealy); state and counter update on the rising clk edge.
- Flush overrides enable at the destination register.
- Reset:
  - While reset=1: all *_en=0, all flushes=0, mul_busy=0.
  - On the next edge: state=RUN, mul_cnt=0.
  - Reset during MUL aborts the multiply.
- Default (no event): all *_en=1, all flushes=0.
- State RUN, evaluated in priority order:
  1. ex_br_taken=1: if_id_flush=1, id_ex_flush=1, all enables 1; stay in RUN. Multiply start and load-use are suppressed this cycle.
  2. ex_is_mul=1 and MUL_CYCLES>1:
     - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_flush=1.
     - mem_wb_en=1 so older instructions drain.
     - mul_cnt <= MUL_CYCLES-1; next state MUL.
  3. Load-use hazard, defined as ex_mem_read=1 and ex_rd != ZERO_REG and ((id_uses_rn and id_rn==ex_rd) or (id_uses_rm and id_rm==ex_rd)):
     - pc_en=0, if_id_en=0, id_ex_flush=1.
     - Stay in RUN; exactly one bubble is inserted.
- State MUL: mul_busy=1. ex_br_taken and the hazard inputs are ignored.
  - mul_cnt > 1: same freeze outputs as the RUN multiply start; mul_cnt decrements.
  - mul_cnt == 1: release, all enables 1, no flushes; next state RUN.
  - The multiply therefore occupies EX for exactly MUL_CYCLES cycles.
  - A multiply entering EX in the following RUN cycle starts a fresh sequence (back-to-back multiplies allowed).
- MUL_CYCLES=1: the MUL state is never entered.
- The load-use check is independent of the mul path and uses the same equality on both source ports.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [CNT_W-1:0].
  - Increments on each clock edge where reset=0 and pc_en=0.
  - Saturates at all-ones; cleared to 0 by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with ex_is_mul=1 -> all *_en=0 and mul_busy=0 during reset; first cycle after release is RUN with mul start (pc_en=0, ex_mem_flush=1).
2. Load-use: ex_mem_read=1, ex_rd=3, id_rn=3, id_uses_rn=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Repeat with ex_rd=31 -> no stall.
3. Multiply, MUL_CYCLES=4: ex_is_mul=1 held -> pc_en=0 for exactly 3 consecutive cycles, mul_busy=1 for cycles 2-4, all enables 1 on cycle 4, then RUN.
4. Branch priority: ex_br_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_en=1, no stall.
5. Back-to-back multiplies: two multiplies in EX consecutively -> two freeze windows of 3 stall cycles each, separated by one release cycle.
6. PIPE_STALL_CNT_EN defined: run scenarios 2 and 3 -> stall_cycles=4. Preload near CNT_W saturation (CNT_W=3) -> holds at 7.
